// File: rtl/atm_portdec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// atm_portdec : ATM/Pentagon-1M I/O port decoder (7FFD, EFF7, xxF7, xx77, DOS)
// Rev 1.0
// ---------------------------------------------------------------------------
module atm_portdec (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        zpos,
   input  logic        zneg,
   input  logic [15:0] za,
   input  logic [7:0]  zd,
   input  logic        iorq_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        dos_turn_on,
   input  logic        dos_turn_off,
   output logic        dos,
   output logic        pent1m_ROM,
   output logic [5:0]  pent1m_page,
   output logic        scr_page,
   output logic        pent1m_ram0_0,
   output logic        pent1m_1m_on,
   output logic        pager_off,
   output logic        turbo,
   output logic        atmF7_wr
);

   logic       iowr_reg_q, iowr_reg_d;
   logic       dos_q, dos_d;
   logic [5:0] page_q, page_d;
   logic       rom_q, rom_d;
   logic       scr_q, scr_d;
   logic       ram0_q, ram0_d;
   logic       on1m_q, on1m_d;
   logic       poff_q, poff_d;
   logic       turbo_q, turbo_d;
   logic       d5_q, d5_d;

   logic iowr, stb, lock;
   logic wr_7ffd, wr_eff7, wr_xxf7, wr_xx77;
   logic unused_zneg;

   assign unused_zneg = zneg;

   always_comb begin
      iowr    = ~iorq_n & ~wr_n & m1_n;
      // Gated by rst_n so no strobe can leak out while reset is held.
      stb     = rst_n & zpos & iowr & ~iowr_reg_q;
      lock    = d5_q & ~on1m_q;
      wr_7ffd = stb & ~za[15] & ~za[1] & ~lock;
      wr_eff7 = stb & (za == 16'hEFF7) & ~dos_q;
      wr_xxf7 = stb & (za[7:0] == 8'hF7) & dos_q;
      wr_xx77 = stb & (za[7:0] == 8'h77) & dos_q;

      iowr_reg_d = zpos ? iowr : iowr_reg_q;
      dos_d      = dos_q;
      page_d     = page_q;
      rom_d      = rom_q;
      scr_d      = scr_q;
      ram0_d     = ram0_q;
      on1m_d     = on1m_q;
      poff_d     = poff_q;
      turbo_d    = turbo_q;
      d5_d       = d5_q;

      if (dos_turn_on)
         dos_d = 1'b1;
      else if (dos_turn_off)
         dos_d = 1'b0;

      if (wr_7ffd) begin
         page_d = {zd[5], zd[6], zd[7], zd[2:0]};
         scr_d  = zd[3];
         rom_d  = zd[4];
         d5_d   = zd[5];
      end

      if (wr_eff7) begin
         on1m_d = ~zd[2];
         ram0_d = zd[3];
      end

      if (wr_xx77) begin
         poff_d  = ~za[8];
         turbo_d = zd[3];
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         iowr_reg_q <= 1'b0;
         dos_q      <= 1'b0;
         page_q     <= 6'd0;
         rom_q      <= 1'b0;
         scr_q      <= 1'b0;
         ram0_q     <= 1'b0;
         on1m_q     <= 1'b0;
         poff_q     <= 1'b0;
         turbo_q    <= 1'b0;
         d5_q       <= 1'b0;
      end else begin
         iowr_reg_q <= iowr_reg_d;
         dos_q      <= dos_d;
         page_q     <= page_d;
         rom_q      <= rom_d;
         scr_q      <= scr_d;
         ram0_q     <= ram0_d;
         on1m_q     <= on1m_d;
         poff_q     <= poff_d;
         turbo_q    <= turbo_d;
         d5_q       <= d5_d;
      end
   end

   assign dos           = dos_q;
   assign pent1m_ROM    = rom_q;
   assign pent1m_page   = page_q;
   assign scr_page      = scr_q;
   assign pent1m_ram0_0 = ram0_q;
   assign pent1m_1m_on  = on1m_q;
   assign pager_off     = poff_q;
   assign turbo         = turbo_q;
   assign atmF7_wr      = wr_xxf7;

endmodule
`default_nettype wire

// File: tb/tb_atm_portdec.sv
`default_nettype none
// Directed table-driven bench for atm_portdec.
module tb_atm_portdec;

   logic        fclk = 1'b0;
   logic        rst_n, zpos, zneg;
   logic [15:0] za;
   logic [7:0]  zd;
   logic        iorq_n, wr_n, m1_n;
   logic        dos_turn_on, dos_turn_off;
   logic        dos, pent1m_ROM, scr_page, pent1m_ram0_0, pent1m_1m_on;
   logic        pager_off, turbo, atmF7_wr;
   logic [5:0]  pent1m_page;

   int n_vec  = 0;
   int n_fail = 0;

   atm_portdec dut (
      .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
      .iorq_n(iorq_n), .wr_n(wr_n), .m1_n(m1_n),
      .dos_turn_on(dos_turn_on), .dos_turn_off(dos_turn_off),
      .dos(dos), .pent1m_ROM(pent1m_ROM), .pent1m_page(pent1m_page),
      .scr_page(scr_page), .pent1m_ram0_0(pent1m_ram0_0),
      .pent1m_1m_on(pent1m_1m_on), .pager_off(pager_off), .turbo(turbo),
      .atmF7_wr(atmF7_wr)
   );

   always #5 fclk = ~fclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  dcmd;   // 0 none, 1 dos_turn_on, 2 dos_turn_off
      logic [15:0] a;
      logic [7:0]  d;
      logic        m1n;
      logic [5:0]  page;
      logic        rom, scr, ram0, on1m, poff, turbo, dos;
      int          f7;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic zp, inout int f7);
      zpos = zp;
      zneg = 1'b0;
      @(negedge fclk);
      if (atmF7_wr === 1'b1) f7++;
      @(posedge fclk);
      #1;
      zpos = 1'b0;
   endtask

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input logic m1n, output int f7);
      int c = 0;
      za = a; zd = d; m1_n = m1n; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (3) begin
         tick(1'b0, c); tick(1'b0, c); tick(1'b0, c); tick(1'b1, c);
      end
      iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
      repeat (2) begin
         tick(1'b0, c); tick(1'b1, c);
      end
      f7 = c;
   endtask

   task automatic dos_pulse(input logic on, input logic off);
      dos_turn_on = on; dos_turn_off = off;
      @(posedge fclk);
      #1;
      dos_turn_on = 1'b0; dos_turn_off = 1'b0;
   endtask

   task automatic chk_all(input string tag, input vec_t v, input int f7);
      n_vec++;
      chk({tag, " page"},  {26'd0, pent1m_page},   {26'd0, v.page});
      chk({tag, " rom"},   {31'd0, pent1m_ROM},    {31'd0, v.rom});
      chk({tag, " scr"},   {31'd0, scr_page},      {31'd0, v.scr});
      chk({tag, " ram0"},  {31'd0, pent1m_ram0_0}, {31'd0, v.ram0});
      chk({tag, " 1m_on"}, {31'd0, pent1m_1m_on},  {31'd0, v.on1m});
      chk({tag, " poff"},  {31'd0, pager_off},     {31'd0, v.poff});
      chk({tag, " turbo"}, {31'd0, turbo},         {31'd0, v.turbo});
      chk({tag, " dos"},   {31'd0, dos},           {31'd0, v.dos});
      chk({tag, " f7cnt"}, f7,                     v.f7);
   endtask

   initial begin
      int   f7;
      vec_t z;
      //        dcmd  addr      data   m1n  page   rom scr ram0 1m poff tb dos f7
      vecs[0]  = '{2'd0, 16'h7FFD, 8'h17, 1'b1, 6'h07, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{2'd0, 16'h7FFD, 8'h20, 1'b1, 6'h20, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{2'd0, 16'h7FFD, 8'h07, 1'b1, 6'h20, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{2'd0, 16'hEFF7, 8'h00, 1'b1, 6'h20, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[4]  = '{2'd0, 16'h7FFD, 8'h07, 1'b1, 6'h07, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[5]  = '{2'd0, 16'hEFF7, 8'h0C, 1'b1, 6'h07, 0, 0, 1, 0, 0, 0, 0, 0};
      vecs[6]  = '{2'd1, 16'h3FF7, 8'h55, 1'b1, 6'h07, 0, 0, 1, 0, 0, 0, 1, 1};
      vecs[7]  = '{2'd0, 16'h0077, 8'h08, 1'b1, 6'h07, 0, 0, 1, 0, 1, 1, 1, 0};
      vecs[8]  = '{2'd0, 16'h0177, 8'h00, 1'b1, 6'h07, 0, 0, 1, 0, 0, 0, 1, 0};
      vecs[9]  = '{2'd0, 16'hEFF7, 8'h04, 1'b1, 6'h07, 0, 0, 1, 0, 0, 0, 1, 1};
      vecs[10] = '{2'd0, 16'h0077, 8'h08, 1'b1, 6'h07, 0, 0, 1, 0, 1, 1, 1, 0};
      vecs[11] = '{2'd2, 16'h0077, 8'h00, 1'b1, 6'h07, 0, 0, 1, 0, 1, 1, 0, 0};
      vecs[12] = '{2'd0, 16'h7FFD, 8'h1F, 1'b0, 6'h07, 0, 0, 1, 0, 1, 1, 0, 0};
      vecs[13] = '{2'd0, 16'h7FFD, 8'hE8, 1'b1, 6'h38, 0, 1, 1, 0, 1, 1, 0, 0};
      vecs[14] = '{2'd0, 16'h7FFD, 8'h00, 1'b1, 6'h38, 0, 1, 1, 0, 1, 1, 0, 0};

      rst_n = 1'b0; zpos = 1'b0; zneg = 1'b0; za = 16'h0; zd = 8'h0;
      iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
      dos_turn_on = 1'b0; dos_turn_off = 1'b0;
      z = '{2'd0, 16'h0, 8'h0, 1'b1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0};
      repeat (3) @(posedge fclk);
      @(negedge fclk);
      chk_all("reset", z, 0);
      @(posedge fclk);
      #1;
      rst_n = 1'b1;
      f7 = 0;
      tick(1'b0, f7);

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].dcmd == 2'd1) dos_pulse(1'b1, 1'b0);
         if (vecs[i].dcmd == 2'd2) dos_pulse(1'b0, 1'b1);
         io_wr(vecs[i].a, vecs[i].d, vecs[i].m1n, f7);
         @(negedge fclk);
         chk_all($sformatf("vec%0d", i), vecs[i], f7);
         @(posedge fclk);
         #1;
      end

      // Both dos requests together set dos; turn-off alone clears it.
      dos_pulse(1'b1, 1'b1);
      @(negedge fclk);
      n_vec++;
      chk("dos both", {31'd0, dos}, 32'd1);
      @(posedge fclk); #1;
      dos_pulse(1'b0, 1'b1);
      @(negedge fclk);
      n_vec++;
      chk("dos off", {31'd0, dos}, 32'd0);
      @(posedge fclk); #1;
      dos_pulse(1'b1, 1'b0);

      // Reset asserted in the middle of an xxF7 write: no strobe, registers cleared.
      za = 16'h3FF7; zd = 8'h00; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
      f7 = 0;
      tick(1'b0, f7);
      zpos = 1'b1;
      rst_n = 1'b0;
      @(negedge fclk);
      if (atmF7_wr === 1'b1) f7++;
      chk_all("mid-reset", z, 0);
      @(posedge fclk); #1;
      zpos = 1'b0;
      rst_n = 1'b1;
      iorq_n = 1'b1; wr_n = 1'b1;
      f7 = 0;
      tick(1'b1, f7);
      tick(1'b0, f7);

      // Lock is gone after reset, 7FFD writable again.
      io_wr(16'h7FFD, 8'h17, 1'b1, f7);
      @(negedge fclk);
      z = '{2'd0, 16'h0, 8'h0, 1'b1, 6'h07, 1, 0, 0, 0, 0, 0, 0, 0};
      chk_all("post-reset", z, f7);
      @(posedge fclk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
